pmem_scheduler: RTL and testbench

- Round-robin scheduler that shares the single physical-memory port between the instruction cache and the data cache.
- Sits between both caches' pmem-side interfaces and the external memory.
- Latches one transaction at a time, sequences it through a small FSM, and routes the response back to the winner.
- Generates the pipeline-wide ld_regs hold signal and exposes grant counters and a timeout flag for debug.

---
 rtl/pmem_scheduler_pkg.sv | 26 ++
 rtl/pmem_scheduler_sat_counter16.sv | 39 +++
 rtl/pmem_scheduler.sv | 171 +++++++++++++++++
 tb/tb_pmem_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_scheduler_pkg.sv
// Shared LC-3b types for the physical-memory scheduler: word/line types,
// FSM states, requester identity and a saturating-increment helper.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_block;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } pmem_sched_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } pmem_requester_t;

  localparam logic [15:0] SAT16_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == SAT16_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pmem_scheduler_sat_counter16.sv
// 16-bit counter with a synchronous load and an increment that sticks at 16'hFFFF.
module sat_counter16
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: load wins over increment.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = sat_inc16(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pmem_scheduler.sv
// Round-robin arbiter sharing one physical-memory port between icache and dcache,
// with registered memory strobes, grant counters and a sticky wait timeout.
module pmem_scheduler
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WIDTH = 128,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0]  icache_pmem_address,
  output logic                   icache_pmem_resp,
  input  logic                   dcache_pmem_read,
  input  logic                   dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0]  dcache_pmem_address,
  input  logic [BLOCK_WIDTH-1:0] dcache_pmem_wdata,
  output logic                   dcache_pmem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [ADDR_WIDTH-1:0]  pmem_address,
  output logic [BLOCK_WIDTH-1:0] pmem_wdata,
  input  logic                   pmem_resp,
  output logic                   ld_regs,
  output logic [15:0]            grant_count_i,
  output logic [15:0]            grant_count_d,
  output logic                   timeout_err
);

  localparam int WAIT_W = (TIMEOUT <= 255) ? 8 : $clog2(TIMEOUT + 1);

  pmem_sched_state_t      state_q, state_d;
  pmem_requester_t        last_grant_q, last_grant_d;
  logic                   pmem_read_q, pmem_read_d;
  logic                   pmem_write_q, pmem_write_d;
  logic [ADDR_WIDTH-1:0]  pmem_address_q, pmem_address_d;
  logic [BLOCK_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   timeout_err_q, timeout_err_d;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;

  assign req_i = icache_pmem_read;
  assign req_d = dcache_pmem_read | dcache_pmem_write;

  // Arbitration, transaction latching, wait tracking and response routing.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    pmem_read_d      = pmem_read_q;
    pmem_write_d     = pmem_write_q;
    pmem_address_d   = pmem_address_q;
    pmem_wdata_d     = pmem_wdata_q;
    wait_d           = wait_q;
    timeout_err_d    = timeout_err_q;
    grant_i          = 1'b0;
    grant_d          = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;

    case (state_q)
      IDLE: begin
        // dcache wins when alone, or on a tie if icache had the last grant.
        if (req_d && (!req_i || (last_grant_q == REQ_I))) begin
          grant_d        = 1'b1;
          state_d        = GRANT_D;
          last_grant_d   = REQ_D;
          pmem_address_d = dcache_pmem_address;
          pmem_wdata_d   = dcache_pmem_wdata;
          pmem_write_d   = dcache_pmem_write;
          pmem_read_d    = ~dcache_pmem_write;
          wait_d         = '0;
        end else if (req_i) begin
          grant_i        = 1'b1;
          state_d        = GRANT_I;
          last_grant_d   = REQ_I;
          pmem_address_d = icache_pmem_address;
          pmem_write_d   = 1'b0;
          pmem_read_d    = 1'b1;
          wait_d         = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (state_q == GRANT_I) begin
          icache_pmem_resp = pmem_resp;
        end else begin
          dcache_pmem_resp = pmem_resp;
        end
        if (pmem_resp) begin
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = RELEASE;
        end else begin
          if (wait_q != {WAIT_W{1'b1}}) begin
            wait_d = wait_q + WAIT_W'(1);
          end else begin
            wait_d = wait_q;
          end
          if ((TIMEOUT != 0) && ((int'(wait_q) + 1) >= TIMEOUT)) begin
            timeout_err_d = 1'b1;
          end else begin
            timeout_err_d = timeout_err_q;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // Scheduler state and latched transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_grant_q   <= REQ_I;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      wait_q         <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      wait_q         <= wait_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  sat_counter16 u_cnt_i (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (1'b0),
    .load_val (16'h0000),
    .inc      (grant_i),
    .count    (grant_count_i)
  );

  sat_counter16 u_cnt_d (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (1'b0),
    .load_val (16'h0000),
    .inc      (grant_d),
    .count    (grant_count_d)
  );

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign timeout_err  = timeout_err_q;
  assign ld_regs      = (state_q == IDLE) && !req_i && !req_d;

endmodule

// File: tb/tb_pmem_scheduler.sv
// Self-checking bench for pmem_scheduler: vector table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_pmem_scheduler;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic         ld_regs;
  logic [15:0]  grant_count_i;
  logic [15:0]  grant_count_d;
  logic         timeout_err;

  logic         s_load;
  logic [15:0]  s_load_val;
  logic         s_inc;
  logic [15:0]  s_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pmem_scheduler #(.ADDR_WIDTH(16), .BLOCK_WIDTH(128), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_resp           (pmem_resp),
    .ld_regs             (ld_regs),
    .grant_count_i       (grant_count_i),
    .grant_count_d       (grant_count_d),
    .timeout_err         (timeout_err)
  );

  sat_counter16 u_sat (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (s_load),
    .load_val (s_load_val),
    .inc      (s_inc),
    .count    (s_count)
  );

  typedef struct {
    logic [3:0]  in4;   // {icache_read, dcache_read, dcache_write, pmem_resp}
    logic [15:0] ai;
    logic [15:0] ad;
    logic [3:0]  ex4;   // {icache_resp, dcache_resp, pmem_read, pmem_write}
    logic [15:0] ea;
    logic        eld;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic [3:0] in4, input logic [15:0] ai,
                               input logic [15:0] ad, input logic [3:0] ex4,
                               input logic [15:0] ea, input logic eld);
    vec_t v;
    v.in4 = in4; v.ai = ai; v.ad = ad; v.ex4 = ex4; v.ea = ea; v.eld = eld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ri, input logic dr, input logic dw, input logic rsp,
                       input logic [15:0] ai, input logic [15:0] ad, input logic [127:0] wd);
    icache_pmem_read    = ri;
    dcache_pmem_read    = dr;
    dcache_pmem_write   = dw;
    pmem_resp           = rsp;
    icache_pmem_address = ai;
    dcache_pmem_address = ad;
    dcache_pmem_wdata   = wd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference model state (transaction level).
  bit          m_busy, m_release, m_write, m_owner_d, m_last_d, m_err;
  logic [15:0] m_addr;
  logic [127:0] m_wdata;
  int          m_waits, m_cnt_i, m_cnt_d;

  task automatic model_reset();
    m_busy = 0; m_release = 0; m_write = 0; m_owner_d = 0; m_last_d = 0; m_err = 0;
    m_addr = 16'h0000; m_wdata = 128'h0; m_waits = 0; m_cnt_i = 0; m_cnt_d = 0;
  endtask

  initial begin
    logic [127:0] wb;
    s_load = 1'b0; s_load_val = 16'h0000; s_inc = 1'b0;
    do_reset();
    #1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_addr", pmem_address, 16'h0000);
    chk("rst_wdata", pmem_wdata, 128'h0);
    chk("rst_cnt_i", grant_count_i, 16'h0000);
    chk("rst_cnt_d", grant_count_d, 16'h0000);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_ld_regs", ld_regs, 1'b1);
    chk("rst_sat", s_count, 16'h0000);

    // Tie after reset (D,I,D,I) followed by a single icache read.
    tbl.push_back(row(4'b0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 1'b1));
    tbl.push_back(row(4'b1100, 16'h2000, 16'h3000, 4'b0000, 16'h0000, 1'b0));
    tbl.push_back(row(4'b1101, 16'h2000, 16'h3000, 4'b0110, 16'h3000, 1'b0));
    tbl.push_back(row(4'b1100, 16'h2000, 16'h3000, 4'b0000, 16'h3000, 1'b0));
    tbl.push_back(row(4'b1100, 16'h2000, 16'h3000, 4'b0000, 16'h3000, 1'b0));
    tbl.push_back(row(4'b1101, 16'h2000, 16'h3000, 4'b1010, 16'h2000, 1'b0));
    tbl.push_back(row(4'b1100, 16'h2000, 16'h3000, 4'b0000, 16'h2000, 1'b0));
    tbl.push_back(row(4'b1100, 16'h2000, 16'h3000, 4'b0000, 16'h2000, 1'b0));
    tbl.push_back(row(4'b1101, 16'h2000, 16'h3000, 4'b0110, 16'h3000, 1'b0));
    tbl.push_back(row(4'b1100, 16'h2000, 16'h3000, 4'b0000, 16'h3000, 1'b0));
    tbl.push_back(row(4'b1100, 16'h2000, 16'h3000, 4'b0000, 16'h3000, 1'b0));
    tbl.push_back(row(4'b1101, 16'h2000, 16'h3000, 4'b1010, 16'h2000, 1'b0));
    tbl.push_back(row(4'b0000, 16'h2000, 16'h3000, 4'b0000, 16'h2000, 1'b0));
    tbl.push_back(row(4'b0000, 16'h2000, 16'h3000, 4'b0000, 16'h2000, 1'b1));
    tbl.push_back(row(4'b1000, 16'h1230, 16'h0000, 4'b0000, 16'h2000, 1'b0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(row(4'b1000, 16'h1230, 16'h0000, 4'b0010, 16'h1230, 1'b0));
    tbl.push_back(row(4'b1001, 16'h1230, 16'h0000, 4'b1010, 16'h1230, 1'b0));
    tbl.push_back(row(4'b0000, 16'h1230, 16'h0000, 4'b0000, 16'h1230, 1'b0));
    tbl.push_back(row(4'b0000, 16'h1230, 16'h0000, 4'b0000, 16'h1230, 1'b1));
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      drive(tbl[r].in4[3], tbl[r].in4[2], tbl[r].in4[1], tbl[r].in4[0],
            tbl[r].ai, tbl[r].ad, 128'h0);
      #1;
      chk($sformatf("tbl%0d_iresp", r), icache_pmem_resp, tbl[r].ex4[3]);
      chk($sformatf("tbl%0d_dresp", r), dcache_pmem_resp, tbl[r].ex4[2]);
      chk($sformatf("tbl%0d_rd", r), pmem_read, tbl[r].ex4[1]);
      chk($sformatf("tbl%0d_wr", r), pmem_write, tbl[r].ex4[0]);
      chk($sformatf("tbl%0d_addr", r), pmem_address, tbl[r].ea);
      chk($sformatf("tbl%0d_ld", r), ld_regs, tbl[r].eld);
    end
    chk("tbl_cnt_i", grant_count_i, 16'd3);
    chk("tbl_cnt_d", grant_count_d, 16'd2);
    chk("tbl_timeout", timeout_err, 1'b0);

    // Write-back with requester inputs changing mid-transaction.
    do_reset();
    wb = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h8000, wb);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, (k == 3), 16'h0000, 16'h1111, {4{$urandom}});
      #1;
      chk("wb_write", pmem_write, 1'b1);
      chk("wb_read", pmem_read, 1'b0);
      chk("wb_addr", pmem_address, 16'h8000);
      chk("wb_wdata", pmem_wdata, wb);
      chk("wb_dresp", dcache_pmem_resp, (k == 3));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
    #1;
    chk("rel_write", pmem_write, 1'b0);
    chk("rel_read", pmem_read, 1'b0);
    chk("rel_ld", ld_regs, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h4444, 16'h0000, 128'h0);
    #1;
    chk("post_rel_strobe", pmem_read, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h4444, 16'h0000, 128'h0);
    #1;
    chk("post_rel_grant", pmem_read, 1'b1);
    chk("post_rel_addr", pmem_address, 16'h4444);
    chk("post_rel_iresp", icache_pmem_resp, 1'b1);
    chk("wb_cnt_d", grant_count_d, 16'd1);

    // Timeout: resp withheld for 19 grant cycles, delivered on the 20th.
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0ABC, 16'h0000, 128'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, (k == 20), 16'h0ABC, 16'h0000, 128'h0);
      #1;
      chk($sformatf("to_err_c%0d", k), timeout_err, (k > TO));
      chk($sformatf("to_iresp_c%0d", k), icache_pmem_resp, (k == 20));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
    @(negedge clk);
    #1;
    chk("to_idle_ld", ld_regs, 1'b1);
    chk("to_sticky", timeout_err, 1'b1);

    // Reset asserted mid GRANT_D write.
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5A5A, 128'h1234);
    @(negedge clk);
    #1;
    chk("mid_write", pmem_write, 1'b1);
    #1;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
    #1;
    chk("mid_rst_write", pmem_write, 1'b0);
    chk("mid_rst_addr", pmem_address, 16'h0000);
    chk("mid_rst_cnt_d", grant_count_d, 16'h0000);
    chk("mid_rst_ld", ld_regs, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // Saturating counter via its load port.
    @(negedge clk);
    s_load = 1'b1; s_load_val = 16'hFFFD; s_inc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_load = 1'b0; s_inc = 1'b1;
      #1;
      chk($sformatf("sat_%0d", k), s_count, (k == 0) ? 16'hFFFD : (k == 1) ? 16'hFFFE : 16'hFFFF);
    end
    s_inc = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic ri, dr, dw, rsp, req_d;
      logic [15:0] ai, ad;
      logic [127:0] wd;
      @(negedge clk);
      ri = ($urandom_range(3) == 0);
      dr = ($urandom_range(3) == 0);
      dw = ($urandom_range(4) == 0);
      rsp = m_busy && ($urandom_range(2) == 0);
      ai = 16'($urandom); ad = 16'($urandom); wd = {$urandom, $urandom, $urandom, $urandom};
      drive(ri, dr, dw, rsp, ai, ad, wd);
      req_d = dr | dw;
      #1;
      chk("rnd_iresp", icache_pmem_resp, m_busy && !m_owner_d && rsp);
      chk("rnd_dresp", dcache_pmem_resp, m_busy && m_owner_d && rsp);
      chk("rnd_rd", pmem_read, m_busy && !m_write);
      chk("rnd_wr", pmem_write, m_busy && m_write);
      chk("rnd_addr", pmem_address, m_addr);
      chk("rnd_wdata", pmem_wdata, m_wdata);
      chk("rnd_ld", ld_regs, !m_busy && !m_release && !ri && !req_d);
      chk("rnd_err", timeout_err, m_err);
      chk("rnd_cnt_i", grant_count_i, 16'(m_cnt_i));
      chk("rnd_cnt_d", grant_count_d, 16'(m_cnt_d));
      if (m_release) begin
        m_release = 0;
      end else if (m_busy) begin
        if (rsp) begin
          m_busy = 0; m_release = 1;
        end else begin
          if (m_waits < 255) m_waits++;
          if (m_waits >= TO) m_err = 1;
        end
      end else if (req_d && (!ri || !m_last_d)) begin
        m_busy = 1; m_owner_d = 1; m_last_d = 1; m_waits = 0;
        m_addr = ad; m_wdata = wd; m_write = dw;
        if (m_cnt_d < 65535) m_cnt_d++;
      end else if (ri) begin
        m_busy = 1; m_owner_d = 0; m_last_d = 0; m_waits = 0;
        m_addr = ai; m_write = 0;
        if (m_cnt_i < 65535) m_cnt_i++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
